// File: rtl/stepper_mmio_ctrl.sv
// stepper_mmio_ctrl
//   Memory-mapped stepper-motor peripheral on the processor dmem bus.
//   Firmware programs a step count/direction, a step period and a control
//   word; the block walks an 8-entry coil-phase table and drives JA.
//
//   Bus semantics: a write is accepted on any posedge where wren=1 and
//   address_dmem[11:0] falls in BASE_ADDR..BASE_ADDR+3; there is no
//   back-pressure. Reads are unqualified: every cycle the addressed register
//   is captured into rd_data/rd_hit, so data appears one cycle after the
//   address and reflects register contents before any same-edge write.
//
// Ports
//   clock         system clock (posedge)
//   reset         synchronous active-high reset
//   wren          dmem write enable
//   address_dmem  dmem word address, [11:0] decoded
//   data          dmem write data
//   rd_data       registered read data (0 on a miss)
//   rd_hit        registered address-hit flag
//   JA            [3:0] coil phases, [4] driver enable, [5] busy
module stepper_mmio_ctrl #(
    parameter logic [11:0] BASE_ADDR   = 12'hF00,
    parameter int          PERIOD_W    = 24,
    parameter int          DEFAULT_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [5:0]  JA
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

    state_t              state, state_nxt;
    logic [15:0]         remaining;
    logic                dir;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] counter;
    logic                enable;
    logic                half_step;
    logic [2:0]          idx;

    // Address decode
    logic [11:0] addr_lo;
    logic [11:0] offset_full;
    logic        in_range;
    logic [1:0]  offset;

    assign addr_lo     = address_dmem[11:0];
    assign offset_full = addr_lo - BASE_ADDR;
    assign in_range    = (addr_lo >= BASE_ADDR) && (offset_full < 12'd4);
    assign offset      = offset_full[1:0];

    logic wr_steps, wr_period, wr_ctrl;
    assign wr_steps  = wren && in_range && (offset == 2'd0);
    assign wr_period = wren && in_range && (offset == 2'd1);
    assign wr_ctrl   = wren && in_range && (offset == 2'd2);

    logic ctrl_abort, ctrl_disable, busy, expire, step;
    assign ctrl_abort   = wr_ctrl && data[2];
    assign ctrl_disable = wr_ctrl && !data[0];
    assign busy         = (state == RUN);
    assign expire       = busy && (counter == '0);
    // A STEPS write, abort or disable on the expiry edge suppresses that step;
    // the countdown itself still reloads so the cadence is unchanged.
    assign step         = expire && !wr_steps && !ctrl_abort && !ctrl_disable;

    // Unused bus bits, gathered so the intent is explicit.
    logic unused_bits;
    assign unused_bits = &{1'b0, address_dmem[31:12], data[30:PERIOD_W]};

    // Next phase index: full-step lands on odd (two-coil) entries.
    logic [2:0] delta, idx_nxt;
    assign delta   = (half_step || !idx[0]) ? 3'd1 : 3'd2;
    assign idx_nxt = dir ? (idx - delta) : (idx + delta);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((wr_steps && (data[15:0] != 16'd0) && enable) ||
                    (wr_ctrl && data[0] && !data[2] && (remaining != 16'd0)))
                    state_nxt = RUN;
            end
            RUN: begin
                if (ctrl_abort || ctrl_disable ||
                    (wr_steps && (data[15:0] == 16'd0)) ||
                    (step && (remaining == 16'd1)))
                    state_nxt = IDLE;
            end
        endcase
    end

    logic start;
    assign start = (state == IDLE) && (state_nxt == RUN);

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (offset)
            2'd0: rd_mux = {dir, 15'b0, remaining};
            2'd1: rd_mux[PERIOD_W-1:0] = period;
            2'd2: rd_mux = {30'b0, half_step, enable};
            2'd3: rd_mux = {remaining, 12'b0, idx, busy};
        endcase
    end

    logic [3:0] coils;
    always_comb begin
        coils = 4'b0000;
        case (idx)
            3'd0: coils = 4'b1000;
            3'd1: coils = 4'b1100;
            3'd2: coils = 4'b0100;
            3'd3: coils = 4'b0110;
            3'd4: coils = 4'b0010;
            3'd5: coils = 4'b0011;
            3'd6: coils = 4'b0001;
            3'd7: coils = 4'b1001;
        endcase
    end

    assign JA = {busy, enable, enable ? coils : 4'b0000};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            dir       <= 1'b0;
            period    <= PERIOD_W'(DEFAULT_DIV);
            counter   <= '0;
            enable    <= 1'b0;
            half_step <= 1'b0;
            idx       <= '0;
            rd_data   <= '0;
            rd_hit    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start)
                counter <= period - ONE;
            else if (busy)
                counter <= expire ? (period - ONE) : (counter - ONE);

            if (wr_steps) begin
                remaining <= data[15:0];
                dir       <= data[31];
            end else if (ctrl_abort) begin
                remaining <= '0;
            end else if (step) begin
                remaining <= remaining - 16'd1;
            end

            if (wr_period)
                period <= (data[PERIOD_W-1:0] < MIN_PERIOD) ? MIN_PERIOD : data[PERIOD_W-1:0];

            if (wr_ctrl) begin
                enable    <= data[0];
                half_step <= data[1];
            end

            if (step)
                idx <= idx_nxt;

            rd_hit  <= in_range;
            rd_data <= in_range ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_stepper_mmio_ctrl.sv
module tb_stepper_mmio_ctrl;

    localparam logic [11:0] BASE = 12'hF00;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [5:0]  JA;

    always #5 clock = ~clock;

    stepper_mmio_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .JA           (JA)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: step times are absolute cycle numbers.
    // ------------------------------------------------------------------
    logic [3:0] phase_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int          m_cyc = 0;
    int          m_next = 0;
    bit          m_busy = 0;
    int          m_rem = 0;
    bit          m_dir = 0;
    int          m_period = 50000;
    bit          m_en = 0;
    bit          m_half = 0;
    int          m_idx = 0;
    logic [38:0] exp_q[$];

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return {m_dir, 15'b0, 16'(m_rem)};
            1: return 32'(m_period);
            2: return {30'b0, m_half, m_en};
            default: return {16'(m_rem), 12'b0, 3'(m_idx), m_busy};
        endcase
    endfunction

    always @(posedge clock) begin
        int          off;
        bit          hit;
        bit          due;
        int          old_period;
        int          d;
        logic [31:0] rd;
        m_cyc++;
        off = int'(address_dmem[11:0]) - int'(BASE);
        hit = (off >= 0) && (off <= 3);
        if (reset) begin
            m_busy = 0; m_rem = 0; m_dir = 0; m_period = 50000;
            m_en = 0; m_half = 0; m_idx = 0;
            hit = 0; rd = 0;
        end else begin
            rd  = hit ? model_read(off) : 32'd0;
            due = m_busy && (m_cyc == m_next);
            old_period = m_period;
            if (due) m_next = m_cyc + old_period;
            if (wren && hit) begin
                case (off)
                    0: begin
                        m_rem = int'(data[15:0]);
                        m_dir = data[31];
                        due   = 0;
                        if (m_rem == 0) m_busy = 0;
                        else if (!m_busy && m_en) begin
                            m_busy = 1;
                            m_next = m_cyc + old_period;
                        end
                    end
                    1: m_period = (data[23:0] < 24'd2) ? 2 : int'(data[23:0]);
                    2: begin
                        m_en   = data[0];
                        m_half = data[1];
                        if (data[2]) begin
                            m_rem = 0; m_busy = 0; due = 0;
                        end else if (!data[0]) begin
                            m_busy = 0; due = 0;
                        end else if (!m_busy && m_rem != 0) begin
                            m_busy = 1;
                            m_next = m_cyc + old_period;
                        end
                    end
                    default: ;
                endcase
            end
            if (due) begin
                d = m_half ? 1 : ((m_idx % 2 == 1) ? 2 : 1);
                m_idx = m_dir ? (m_idx + 8 - d) % 8 : (m_idx + d) % 8;
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
        end
        exp_q.push_back({hit, rd, m_busy, m_en, m_en ? phase_tab[m_idx] : 4'b0000});
    end

    // Compare process: one expectation per edge, checked half a cycle later.
    always @(negedge clock) begin
        logic [38:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd_hit", 32'(rd_hit), 32'(e[38]));
            check("rd_data", rd_data, e[37:6]);
            check("JA", 32'(JA), 32'(e[5:0]));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Keep writes off edges where a step is due; the step/write overlap
    // there is not a case the register rules define.
    task automatic wait_safe();
        while (m_busy && (m_next == m_cyc + 1)) @(negedge clock);
    endtask

    task automatic bus_write_addr(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clock);
        wait_safe();
        wren = 1'b1; address_dmem = addr; data = val;
        @(negedge clock);
        wren = 1'b0; address_dmem = 32'd0; data = 32'd0;
    endtask

    task automatic wr(input int off, input logic [31:0] val);
        bus_write_addr({20'h0, BASE + 12'(off)}, val);
    endtask

    task automatic rd(input int off, output logic [31:0] val, output logic hit);
        @(negedge clock);
        wren = 1'b0; address_dmem = {20'h0, BASE + 12'(off)};
        @(negedge clock);
        val = rd_data; hit = rd_hit;
        address_dmem = 32'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (JA[5] && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (JA[5]) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic random_traffic(input int n_ops);
        for (int i = 0; i < n_ops; i++) begin
            int          kind;
            int          off;
            logic [31:0] v;
            logic [31:0] up;
            logic [11:0] lo;
            kind = $urandom_range(0, 9);
            up   = $urandom;
            off  = $urandom_range(0, 3);
            if (kind <= 4) begin
                v = $urandom;
                case (off)
                    0: v[15:0] = 16'($urandom_range(0, 12));
                    1: v[23:0] = 24'($urandom_range(0, 5));
                    2: begin
                        v[0] = ($urandom_range(0, 3) != 0);
                        v[2] = ($urandom_range(0, 7) == 0);
                    end
                    default: ;
                endcase
                bus_write_addr({up[31:12], BASE + 12'(off)}, v);
            end else if (kind == 5) begin
                lo = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 12'hEFF))
                                                 : 12'($urandom_range(12'hF04, 12'hFFF));
                bus_write_addr({up[31:12], lo}, $urandom);
            end else if (kind <= 7) begin
                @(negedge clock);
                address_dmem = {up[31:12], BASE + 12'($urandom_range(0, 5))};
                @(negedge clock);
                address_dmem = 32'd0;
            end else begin
                idle($urandom_range(1, 8));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] v;
        logic        h;
        reset = 1'b1; wren = 1'b0; address_dmem = 32'd0; data = 32'd0;
        idle(3);
        reset = 1'b0;

        // Reset state
        check("reset_JA", 32'(JA), 32'd0);
        rd(3, v, h); check("reset_status", v, 32'd0);
        rd(1, v, h); check("reset_period", v, 32'd50000);

        // Full-step forward, PERIOD=4, 3 steps from idx0
        wr(1, 32'd4);
        wr(2, 32'd1);
        wr(0, 32'd3);
        check("fwd_busy", 32'(JA[5]), 32'd1);
        idle(3); check("fwd_k3", 32'(JA[3:0]), 32'(4'b1000));
        idle(1); check("fwd_k4", 32'(JA[3:0]), 32'(4'b1100));
        idle(4); check("fwd_k8", 32'(JA[3:0]), 32'(4'b0110));
        idle(4); check("fwd_k12", 32'(JA), 32'(6'b010011));
        rd(3, v, h); check("fwd_status", v, 32'h0000_000A);

        // PERIOD clamp
        wr(1, 32'd0);
        rd(1, v, h); check("period_clamp", v, 32'd2);

        // Move to idx1, then half-step reverse 9 steps
        wr(0, 32'd2);
        wait_idle(100);
        rd(3, v, h); check("pre_rev_status", v, 32'h0000_0002);
        wr(2, 32'd3);
        wr(0, 32'h8000_0009);
        wait_idle(200);
        rd(3, v, h); check("rev_status", v, 32'h0000_0000);
        rd(0, v, h); check("rev_steps", v, 32'h8000_0000);

        // Abort after 5 full steps
        wr(2, 32'd1);
        wr(1, 32'd3);
        wr(0, 32'd100);
        idle(15);
        wr(2, 32'd5);
        check("abort_busy", 32'(JA[5]), 32'd0);
        rd(3, v, h); check("abort_status", v, 32'h0000_0002);
        wr(2, 32'd0);
        check("disable_JA", 32'(JA), 32'd0);

        // STEPS rewrite mid-run, with a STATUS read while busy
        wr(2, 32'd1);
        wr(0, 32'd10);
        idle(7);
        rd(3, v, h);
        check("busy_read_hit", 32'(h), 32'd1);
        check("busy_read_status", v, 32'h0008_000B);
        wr(0, 32'd2);
        wait_idle(100);
        rd(3, v, h); check("rewrite_status", v, 32'h0000_0006);

        // Out-of-range read
        rd(4, v, h);
        check("miss_hit", 32'(h), 32'd0);
        check("miss_data", v, 32'd0);

        // Randomized traffic against the model
        random_traffic(400);

        // Reset mid-run
        wr(2, 32'd1);
        wr(1, 32'd2);
        wr(0, 32'd50);
        idle(5);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_JA", 32'(JA), 32'd0);
        check("midrun_reset_hit", 32'(rd_hit), 32'd0);
        reset = 1'b0;
        idle(4);
        check("post_reset_JA", 32'(JA), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
